// File: rtl/fetch_pkg.sv
// Shared constants and queue entry type for the instruction fetch queue.
package fetch_pkg;

  localparam logic [6:0]  OPC_B    = 7'b1100000;
  localparam logic [6:0]  OPC_BR   = 7'b1100010;
  localparam logic [31:0] NOP      = 32'hC8000000;
  localparam int          MAX_XLEN = 64;

  typedef logic [MAX_XLEN-1:0] fq_pc_t;

  typedef struct packed {
    fq_pc_t      pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer with synchronous flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // qualify push/pop against occupancy
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // entry storage
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue with ID redirect; define FETCH_EARLY_BRANCH_EN to resolve B/BR
// at fetch time instead of passing them down to ID.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h00000000)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       im_req,
  output logic [XLEN-1:0]            im_addr,
  input  logic [31:0]                im_data,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [XLEN-1:0]            id_pc,
  input  logic                       id_ready,
  input  logic                       redir_valid,
  input  logic [XLEN-1:0]            redir_target,
  output logic [2:0]                 rf_raddr,
  input  logic [XLEN-1:0]            rf_rdata,
  input  logic                       wb_en,
  input  logic [2:0]                 wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_r;
  logic            inflight_r;
  logic [XLEN-1:0] inflight_pc_r;
  logic [CW-1:0]   count_s;
  logic [CW:0]     occupancy_s;
  logic            resp_valid_s;
  logic            branch_s;
  logic [XLEN-1:0] branch_target_s;
  logic            push_s;
  logic            pop_s;
  fq_entry_t       push_entry_s;
  fq_entry_t       head_s;
  logic            unused_s;

  assign im_addr = {pc_r[XLEN-1:2], 2'b00};

  // request gating: in-flight responses reserve a slot so the queue cannot overflow
  always_comb begin
    occupancy_s  = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
    im_req       = !rst && !redir_valid && (occupancy_s < (CW+1)'(DEPTH));
    resp_valid_s = inflight_r && !rst && !redir_valid;
  end

`ifdef FETCH_EARLY_BRANCH_EN
  logic            is_b_s;
  logic            is_br_s;
  logic [XLEN-1:0] offset_s;
  logic [XLEN-1:0] base_s;

  assign rf_raddr = im_data[24:22];

  // early branch decode with write-port bypass of the BR base register
  always_comb begin
    is_b_s   = (im_data[31:25] == OPC_B);
    is_br_s  = (im_data[31:25] == OPC_BR);
    offset_s = {{(XLEN-18){im_data[15]}}, im_data[15:0], 2'b00};
    if (wb_en && (wb_addr == rf_raddr)) begin
      base_s = wb_data;
    end else begin
      base_s = rf_rdata;
    end
    branch_s        = resp_valid_s && (is_b_s || is_br_s);
    branch_target_s = (is_br_s ? base_s : inflight_pc_r) + offset_s;
  end

  assign unused_s = ^{redir_target[1:0], head_s, im_data[21:16]};
`else
  assign rf_raddr        = 3'b000;
  assign branch_s        = 1'b0;
  assign branch_target_s = {XLEN{1'b0}};
  assign unused_s        = ^{redir_target[1:0], head_s, rf_rdata, wb_en, wb_addr, wb_data};
`endif

  // fetch PC and in-flight tracking; priority rst > redirect > early branch > sequential
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {XLEN{1'b0}};
    end else if (redir_valid) begin
      pc_r       <= {redir_target[XLEN-1:2], 2'b00};
      inflight_r <= 1'b0;
    end else if (branch_s) begin
      pc_r       <= {branch_target_s[XLEN-1:2], 2'b00};
      inflight_r <= 1'b0;
    end else if (im_req) begin
      pc_r          <= pc_r + XLEN'(4);
      inflight_r    <= 1'b1;
      inflight_pc_r <= im_addr;
    end else begin
      inflight_r <= 1'b0;
    end
  end

  // enqueue surviving non-branch responses, dequeue on ID handshake
  always_comb begin
    push_s             = resp_valid_s && !branch_s;
    push_entry_s.pc    = fq_pc_t'(inflight_pc_r);
    push_entry_s.instr = im_data;
    pop_s              = id_valid && id_ready;
  end

  fetch_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir_valid),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_entry_s),
    .head      (head_s),
    .count     (count_s)
  );

  // ID-facing view; forced to the idle pattern while reset is held
  always_comb begin
    id_valid = !rst && (count_s != {CW{1'b0}});
    q_count  = rst ? {CW{1'b0}} : count_s;
    if (id_valid) begin
      id_instr = head_s.instr;
      id_pc    = XLEN'(head_s.pc);
    end else begin
      id_instr = NOP;
      id_pc    = {XLEN{1'b0}};
    end
  end

endmodule
